// File: rtl/vend_ctrl_if.sv
// Operator-input / actuator-output bundle of the vending-machine controller.
// Carries the synchronized inputs (coin, ab, press, cancel) and the credit / vend / change outputs.
// master drives the operator inputs (synchronizer or bench); slave is the controller itself.
interface vend_ctrl_if #(
    parameter int BAL_W = 6
) ();
    logic [2:0]       coin;
    logic [1:0]       ab;
    logic             press;
    logic             cancel;
    logic [BAL_W-1:0] balance;
    logic             dispense;
    logic [1:0]       item;
    logic             change_pulse;
    logic             coin_rej;
    logic             err_low;
    logic             busy;

    modport master (
        output coin, ab, press, cancel,
        input  balance, dispense, item, change_pulse, coin_rej, err_low, busy
    );

    modport slave (
        input  coin, ab, press, cancel,
        output balance, dispense, item, change_pulse, coin_rej, err_low, busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending-machine credit / vend / change sequencer with a fixed price table.
// Latency: input captured at edge t, effect on the registered outputs after edge t+1.
// No backpressure: events arriving while busy are rejected (coins) or ignored (press/cancel).
//
// Ports: clk, reset (sync, active-high), bus (vend_ctrl_if.slave):
//   in  coin[2:0], ab[1:0], press, cancel
//   out balance[BAL_W-1:0], dispense, item[1:0], change_pulse, coin_rej, err_low, busy
// Optional build macro VEND_TIMEOUT_EN: refund the credit after TIMEOUT_CYC idle cycles in CREDIT.
module vend_ctrl #(
    parameter int BAL_W       = 6,
    parameter int MAX_BAL     = 40,
    parameter int DISP_CYC    = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic         clk,
    input  logic         reset,
    vend_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

    localparam int               DCW   = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
    localparam logic [BAL_W-1:0] MAX_B = BAL_W'(MAX_BAL);

    // Two register stages: *_q is the captured input, *_qq its previous value.
    // Events are decoded from the pair so a held input yields exactly one event.
    logic [2:0]       coin_q, coin_qq;
    logic             press_q, press_qq;
    logic             cancel_q, cancel_qq;
    logic [1:0]       ab_q;

    state_t           state, state_nxt;
    logic [BAL_W-1:0] bal, bal_nxt;
    logic [DCW-1:0]   disp_cnt, disp_cnt_nxt;
    logic [1:0]       item_r, item_nxt;
    logic             dispense_r, dispense_nxt;
    logic             chg_r, chg_nxt;
    logic             rej_r, rej_nxt;
    logic             err_r, err_nxt;
    logic             busy_r;

    logic             coin_ev, press_ev, cancel_ev;
    logic             coin_ok;
    logic [BAL_W-1:0] coin_val, price, bal_sum;

`ifdef VEND_TIMEOUT_EN
    localparam int    TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0]   to_cnt, to_cnt_nxt;
`endif

    assign coin_ev   = (coin_q != 3'b000) && (coin_qq == 3'b000);
    assign press_ev  = press_q && !press_qq;
    assign cancel_ev = cancel_q && !cancel_qq;

    // Unknown coin codes still form an edge but carry no value and are dropped.
    always_comb begin
        coin_ok  = 1'b1;
        coin_val = '0;
        case (coin_q)
            3'b001:  coin_val = BAL_W'(1);
            3'b010:  coin_val = BAL_W'(2);
            3'b100:  coin_val = BAL_W'(10);
            default: coin_ok  = 1'b0;
        endcase
    end

    always_comb begin
        price = BAL_W'(3);
        case (ab_q)
            2'b00: price = BAL_W'(3);
            2'b01: price = BAL_W'(5);
            2'b10: price = BAL_W'(7);
            2'b11: price = BAL_W'(10);
            default: price = BAL_W'(3);
        endcase
    end

    // Width guarantees MAX_BAL + 10 fits, so this sum never wraps.
    assign bal_sum = bal + coin_val;

    always_comb begin
        state_nxt    = state;
        bal_nxt      = bal;
        item_nxt     = item_r;
        disp_cnt_nxt = disp_cnt;
        dispense_nxt = 1'b0;
        chg_nxt      = 1'b0;
        rej_nxt      = 1'b0;
        err_nxt      = 1'b0;
`ifdef VEND_TIMEOUT_EN
        to_cnt_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                if (coin_ev && coin_ok) begin
                    bal_nxt   = coin_val;
                    state_nxt = CREDIT;
                end
                if (press_ev) begin
                    err_nxt = 1'b1;
                end
            end
            CREDIT: begin
                if (cancel_ev) begin
                    state_nxt = CHANGE;
                end else if (press_ev) begin
                    if (bal >= price) begin
                        bal_nxt      = bal - price;
                        item_nxt     = ab_q;
                        state_nxt    = DISPENSE;
                        dispense_nxt = 1'b1;
                        disp_cnt_nxt = DCW'(DISP_CYC - 1);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (coin_ev && coin_ok) begin
                    if (bal_sum > MAX_B) begin
                        rej_nxt = 1'b1;
                    end else begin
                        bal_nxt = bal_sum;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                else if (!coin_ev) begin
                    if (to_cnt == TOW'(TIMEOUT_CYC - 1)) begin
                        state_nxt = CHANGE;
                    end else begin
                        to_cnt_nxt = to_cnt + TOW'(1);
                    end
                end
`endif
                // A coin landing together with press/cancel loses to them and goes back out.
                if ((cancel_ev || press_ev) && coin_ev && coin_ok) begin
                    rej_nxt = 1'b1;
                end
            end
            DISPENSE: begin
                if (coin_ev && coin_ok) begin
                    rej_nxt = 1'b1;
                end
                if (disp_cnt == '0) begin
                    state_nxt = (bal != '0) ? CHANGE : IDLE;
                end else begin
                    dispense_nxt = 1'b1;
                    disp_cnt_nxt = disp_cnt - DCW'(1);
                end
            end
            CHANGE: begin
                if (coin_ev && coin_ok) begin
                    rej_nxt = 1'b1;
                end
                if (bal != '0) begin
                    chg_nxt = 1'b1;
                    bal_nxt = bal - BAL_W'(1);
                    if (bal == BAL_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coin_q     <= '0;
            coin_qq    <= '0;
            press_q    <= 1'b0;
            press_qq   <= 1'b0;
            cancel_q   <= 1'b0;
            cancel_qq  <= 1'b0;
            ab_q       <= '0;
            state      <= IDLE;
            bal        <= '0;
            item_r     <= '0;
            disp_cnt   <= '0;
            dispense_r <= 1'b0;
            chg_r      <= 1'b0;
            rej_r      <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            coin_q     <= bus.coin;
            coin_qq    <= coin_q;
            press_q    <= bus.press;
            press_qq   <= press_q;
            cancel_q   <= bus.cancel;
            cancel_qq  <= cancel_q;
            ab_q       <= bus.ab;
            state      <= state_nxt;
            bal        <= bal_nxt;
            item_r     <= item_nxt;
            disp_cnt   <= disp_cnt_nxt;
            dispense_r <= dispense_nxt;
            chg_r      <= chg_nxt;
            rej_r      <= rej_nxt;
            err_r      <= err_nxt;
            // Registered from the next state so busy tracks the state register exactly.
            busy_r     <= (state_nxt == DISPENSE) || (state_nxt == CHANGE);
`ifdef VEND_TIMEOUT_EN
            to_cnt     <= to_cnt_nxt;
`endif
        end
    end

    assign bus.balance      = bal;
    assign bus.dispense     = dispense_r;
    assign bus.item         = item_r;
    assign bus.change_pulse = chg_r;
    assign bus.coin_rej     = rej_r;
    assign bus.err_low      = err_r;
    assign bus.busy         = busy_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios then random operator actions.
// Expected pulses/bursts are queued per kind when stimulus is issued; a monitor pops and compares.
// Bench drives inputs #1 after posedge and the monitor samples on negedge.
module tb_vend_ctrl;
    localparam int BAL_W       = 6;
    localparam int MAX_BAL     = 40;
    localparam int DISP_CYC    = 4;
    localparam int TIMEOUT_CYC = 20;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vend_ctrl_if #(.BAL_W(BAL_W)) bus ();

    vend_ctrl #(
        .BAL_W(BAL_W), .MAX_BAL(MAX_BAL), .DISP_CYC(DISP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int credit = 0;          // reference model: credit held while no vend/refund is running

    int q_rej[$];            // balance shown with each coin_rej pulse
    int q_err[$];            // balance shown with each err_low pulse
    int q_disp[$];           // item of each dispense burst
    int q_chg[$];            // length of each change burst

    int disp_run  = 0;
    int disp_item = 0;
    int chg_run   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s got=pulse expected=none at %0t", name, $time);
    endtask

    function automatic int coin_value(input logic [2:0] c);
        case (c)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int price_of(input int a);
        case (a)
            0:       return 3;
            1:       return 5;
            2:       return 7;
            default: return 10;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one-cycle pulses pop per cycle, bursts pop when they end.
    always @(negedge clk) begin
        int e;
        if (reset) begin
            disp_run = 0;
            chg_run  = 0;
        end else begin
            if (bus.coin_rej) begin
                if (q_rej.size() == 0) unexpected("coin_rej");
                else begin
                    e = q_rej.pop_front();
                    chk("rej_balance", int'(bus.balance), e);
                end
            end
            if (bus.err_low) begin
                if (q_err.size() == 0) unexpected("err_low");
                else begin
                    e = q_err.pop_front();
                    chk("err_balance", int'(bus.balance), e);
                end
            end
            if (bus.dispense) begin
                if (disp_run == 0) disp_item = int'(bus.item);
                disp_run++;
            end else if (disp_run > 0) begin
                if (q_disp.size() == 0) unexpected("dispense");
                else begin
                    e = q_disp.pop_front();
                    chk("disp_item", disp_item, e);
                    chk("disp_len", disp_run, DISP_CYC);
                end
                disp_run = 0;
            end
            if (bus.change_pulse) begin
                chg_run++;
            end else if (chg_run > 0) begin
                if (q_chg.size() == 0) unexpected("change");
                else begin
                    e = q_chg.pop_front();
                    chk("chg_count", chg_run, e);
                    chk("chg_end_balance", int'(bus.balance), 0);
                end
                chg_run = 0;
            end
        end
    end

    task automatic settle_check();
        chk("bal_settle", int'(bus.balance), credit);
        chk("busy_settle", int'(bus.busy), 0);
    endtask

    task automatic coin_op(input logic [2:0] code, input int hold);
        int v;
        v = coin_value(code);
        if (v > 0) begin
            if (credit + v > MAX_BAL) q_rej.push_back(credit);
            else credit += v;
        end
        bus.coin = code;
        cyc(hold);
        bus.coin = 3'b000;
        cyc(3);
        settle_check();
    endtask

    // Press (optionally with a coin in the same cycle, or a coin during the dispense).
    task automatic press_op(input int a, input logic [2:0] same_coin, input logic [2:0] busy_coin);
        int  p;
        int  rem;
        int  wait_n;
        bit  vend;
        p      = price_of(a);
        vend   = (credit >= p);
        wait_n = 3;
        rem    = credit;
        if (vend) begin
            rem = credit - p;
            q_disp.push_back(a);
            if (rem > 0) q_chg.push_back(rem);
            wait_n = DISP_CYC + rem + 6;
        end else begin
            q_err.push_back(credit);
        end
        if (credit > 0 && coin_value(same_coin) > 0) q_rej.push_back(rem);
        if (vend && busy_coin != 3'b000 && coin_value(busy_coin) > 0) q_rej.push_back(rem);
        bus.ab    = a[1:0];
        bus.press = 1'b1;
        if (credit > 0) bus.coin = same_coin;
        cyc(1);
        bus.press = 1'b0;
        bus.coin  = 3'b000;
        if (vend && busy_coin != 3'b000) begin
            cyc(1);
            bus.coin = busy_coin;
            cyc(1);
            bus.coin = 3'b000;
        end
        cyc(wait_n);
        credit = vend ? 0 : credit;
        settle_check();
    endtask

    task automatic cancel_op(input bit with_press, input int a);
        int n;
        n = credit;
        if (n > 0) q_chg.push_back(n);
        else if (with_press) q_err.push_back(0);
        bus.ab     = a[1:0];
        bus.cancel = 1'b1;
        bus.press  = with_press;
        cyc(1);
        bus.cancel = 1'b0;
        bus.press  = 1'b0;
        cyc(n + 6);
        credit = 0;
        settle_check();
    endtask

    logic [2:0] codes [8];

    initial begin
        int r;
        bus.coin   = 3'b000;
        bus.ab     = 2'b00;
        bus.press  = 1'b0;
        bus.cancel = 1'b0;
        codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b100; codes[3] = 3'b100;
        codes[4] = 3'b100; codes[5] = 3'b011; codes[6] = 3'b101; codes[7] = 3'b111;

        cyc(2);
        chk("rst_balance", int'(bus.balance), 0);
        chk("rst_dispense", int'(bus.dispense), 0);
        chk("rst_item", int'(bus.item), 0);
        chk("rst_change", int'(bus.change_pulse), 0);
        chk("rst_coin_rej", int'(bus.coin_rej), 0);
        chk("rst_err_low", int'(bus.err_low), 0);
        chk("rst_busy", int'(bus.busy), 0);
        reset = 1'b0;
        cyc(2);

        // Held coin gives one event; then refund it.
        coin_op(3'b010, 3);
        cancel_op(1'b0, 0);
        // 10 + 1 = 11, buy 7 -> 4 change.
        coin_op(3'b100, 1);
        coin_op(3'b001, 2);
        press_op(2, 3'b000, 3'b000);
        // Insufficient credit, then cancel refund of 3.
        coin_op(3'b001, 1);
        coin_op(3'b010, 1);
        press_op(1, 3'b000, 3'b000);
        cancel_op(1'b0, 0);
        // Fill to the cap, overflow coin, then coin during dispense.
        for (int i = 0; i < 4; i++) coin_op(3'b100, 1);
        coin_op(3'b001, 1);
        press_op(3, 3'b000, 3'b100);
        // Press and cancel together: refund wins.
        coin_op(3'b100, 1);
        cancel_op(1'b1, 3);
        // Press in IDLE, cancel in IDLE, coin alongside press.
        press_op(0, 3'b000, 3'b000);
        cancel_op(1'b0, 0);
        coin_op(3'b100, 1);
        press_op(0, 3'b010, 3'b000);

        // Reset in the middle of a refund.
        coin_op(3'b100, 1);
        bus.cancel = 1'b1;
        cyc(1);
        bus.cancel = 1'b0;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        chk("midrst_balance", int'(bus.balance), 0);
        chk("midrst_change", int'(bus.change_pulse), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_dispense", int'(bus.dispense), 0);
        reset  = 1'b0;
        credit = 0;
        cyc(15);
        settle_check();

`ifdef VEND_TIMEOUT_EN
        coin_op(3'b010, 1);
        q_chg.push_back(credit);
        credit = 0;
        cyc(TIMEOUT_CYC + 10);
        settle_check();
`endif

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                coin_op(codes[$urandom_range(0, 7)], $urandom_range(1, 3));
            end else if (r <= 5) begin
                press_op($urandom_range(0, 3), 3'b000,
                         ($urandom_range(0, 1) == 1) ? codes[$urandom_range(0, 7)] : 3'b000);
            end else if (r == 6) begin
                cancel_op(1'b0, 0);
            end else if (r == 7 && credit > 0) begin
                cancel_op(1'b1, $urandom_range(0, 3));
            end else if (r == 8 && credit > 0) begin
                press_op($urandom_range(0, 3), codes[$urandom_range(0, 7)], 3'b000);
            end else begin
                coin_op(3'b100, 1);
            end
        end

        cyc(10);
        chk("left_rej", q_rej.size(), 0);
        chk("left_err", q_err.size(), 0);
        chk("left_disp", q_disp.size(), 0);
        chk("left_chg", q_chg.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
